tile_writeback: RTL and testbench

//  Downstream of the tile renderer. Captures the renderer's per-pixel writes (X, Y, colour, wren) into
//  an on-chip 32x32x16 tile colour buffer. On request, streams the finished tile to the external

---
 rtl/tile_writeback.sv | 209 ++++++++++++++++++++
 tb/tb_tile_writeback.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_writeback.sv
// Tile colour buffer: captures renderer pixel writes and streams the tile out as 32 Avalon-MM row bursts.
// Define TILE_WB_DOUBLE_BUF_EN for two banks, so the renderer fills one bank while the other drains.
module tile_writeback #(
  parameter int unsigned FB_STRIDE  = 640,
  parameter int unsigned TILE_IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_wren,
  input  logic [4:0]            pix_x,
  input  logic [4:0]            pix_y,
  input  logic [15:0]           pix_color,
  input  logic                  tile_done,
  input  logic                  flush_start,
  input  logic [TILE_IDX_W-1:0] tile_col,
  input  logic [TILE_IDX_W-1:0] tile_row,
  input  logic [31:0]           fb_base,
  output logic                  busy,
  output logic                  flush_done,
  output logic                  overrun,
  output logic [31:0]           avm_address,
  output logic                  avm_write,
  output logic [15:0]           avm_writedata,
  output logic [5:0]            avm_burstcount,
  input  logic                  avm_waitrequest
);

`ifdef TILE_WB_DOUBLE_BUF_EN
  localparam int unsigned AW  = 11;
  localparam bit          DBL = 1'b1;
`else
  localparam int unsigned AW  = 10;
  localparam bit          DBL = 1'b0;
`endif
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PREFETCH,
    BURST,
    LAST
  } state_t;

  state_t                  state_q, state_d;
  logic [4:0]              row_q, row_d;
  logic [4:0]              word_q, word_d;
  logic [TILE_IDX_W-1:0]   col_q, col_d;
  logic [TILE_IDX_W-1:0]   trow_q, trow_d;
  logic [31:0]             base_q, base_d;
  logic [31:0]             addr_q, addr_d;
  logic                    overrun_q, overrun_d;

  logic [15:0]             mem [DEPTH];
  logic [15:0]             rd_data_q;
  logic                    rd_en;
  logic [4:0]              rd_word;
  logic [AW-1:0]           rd_addr;
  logic [AW-1:0]           wr_addr;
  logic                    wr_en;
  logic                    conflict;
  logic                    flushing;
  logic                    accept;
  logic [31:0]             line_idx;
  logic [31:0]             pix_off;
  logic [31:0]             addr_calc;

  assign flushing = (state_q != IDLE);
  assign accept   = (state_q == IDLE) && flush_start;

`ifdef TILE_WB_DOUBLE_BUF_EN
  logic bank_q, bank_d;
  logic drain_q, drain_d;

  always_comb begin
    bank_d  = bank_q;
    drain_d = drain_q;
    if (accept) begin
      drain_d = bank_q;
      bank_d  = ~bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      drain_q <= drain_d;
    end
  end

  assign wr_addr  = {bank_q, pix_y, pix_x};
  assign rd_addr  = {drain_q, row_q, rd_word};
  assign conflict = flushing && (bank_q == drain_q);
`else
  assign wr_addr  = {pix_y, pix_x};
  assign rd_addr  = {row_q, rd_word};
  assign conflict = flushing;
`endif

  assign wr_en     = pix_wren && !conflict;
  assign overrun_d = overrun_q || (pix_wren && conflict);

  // Sync-read RAM; the read register doubles as the burst output register.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= pix_color;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  always_comb begin
    line_idx  = 32'(trow_q) * 32'd32 + 32'(row_q);
    pix_off   = line_idx * FB_STRIDE + 32'(col_q) * 32'd32;
    addr_calc = base_q + (pix_off << 1);
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    word_d     = word_q;
    col_d      = col_q;
    trow_d     = trow_q;
    base_d     = base_q;
    addr_d     = addr_q;
    rd_en      = 1'b0;
    rd_word    = 5'd0;
    flush_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_start) begin
          col_d   = tile_col;
          trow_d  = tile_row;
          base_d  = fb_base;
          row_d   = 5'd0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (tile_done || DBL) begin
          state_d = PREFETCH;
        end
      end
      PREFETCH: begin
        rd_en   = 1'b1;
        rd_word = 5'd0;
        word_d  = 5'd0;
        addr_d  = addr_calc;
        state_d = BURST;
      end
      BURST: begin
        if (!avm_waitrequest) begin
          if (word_q == 5'd31) begin
            if (row_q == 5'd31) begin
              state_d = LAST;
            end else begin
              row_d   = row_q + 5'd1;
              state_d = PREFETCH;
            end
          end else begin
            word_d  = word_q + 5'd1;
            rd_en   = 1'b1;
            rd_word = word_q + 5'd1;
          end
        end
      end
      LAST: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      word_q    <= '0;
      col_q     <= '0;
      trow_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      word_q    <= word_d;
      col_q     <= col_d;
      trow_q    <= trow_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy           = (state_q == ARM) || (state_q == PREFETCH) ||
                          (state_q == BURST);
  assign overrun        = overrun_q;
  assign avm_write      = (state_q == BURST);
  assign avm_address    = avm_write ? addr_q : 32'd0;
  assign avm_writedata  = avm_write ? rd_data_q : 16'd0;
  assign avm_burstcount = avm_write ? 6'd32 : 6'd0;

endmodule

// File: tb/tb_tile_writeback.sv
// Directed bench for tile_writeback: capture, row bursts, stalls, ARM wait,
// overrun, back-to-back flushes and mid-burst reset.
module tb_tile_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_wren = 1'b0;
  logic [4:0]  pix_x = '0;
  logic [4:0]  pix_y = '0;
  logic [15:0] pix_color = '0;
  logic        tile_done = 1'b0;
  logic        flush_start = 1'b0;
  logic [4:0]  tile_col = '0;
  logic [4:0]  tile_row = '0;
  logic [31:0] fb_base = '0;
  logic        busy;
  logic        flush_done;
  logic        overrun;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [5:0]  avm_burstcount;
  logic        avm_waitrequest = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [1024];
  logic [15:0] exp_a [1024];

  always #5 clk = ~clk;

  tile_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .pix_wren        (pix_wren),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_color       (pix_color),
    .tile_done       (tile_done),
    .flush_start     (flush_start),
    .tile_col        (tile_col),
    .tile_row        (tile_row),
    .fb_base         (fb_base),
    .busy            (busy),
    .flush_done      (flush_done),
    .overrun         (overrun),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_burstcount  (avm_burstcount),
    .avm_waitrequest (avm_waitrequest)
  );

  function automatic logic [31:0] row_addr(input logic [4:0] col,
                                           input logic [4:0] trow,
                                           input int r,
                                           input logic [31:0] base);
    logic [31:0] line;
    line = 32'(trow) * 32'd32 + 32'(r);
    return base + ((line * 32'd640 + 32'(col) * 32'd32) << 1);
  endfunction

  task automatic fill_tile(input int mode);
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        logic [15:0] c;
        @(negedge clk);
        case (mode)
          0:       c = {y[4:0], x[4:0], 6'b0};
          1:       c = ~{y[4:0], x[4:0], 6'b0};
          default: c = {x[4:0], y[4:0], 6'h15};
        endcase
        pix_wren  = 1'b1;
        pix_x     = x[4:0];
        pix_y     = y[4:0];
        pix_color = c;
        model[y*32+x] = c;
      end
    end
    @(negedge clk);
    pix_wren = 1'b0;
  endtask

  task automatic start_flush(input logic [4:0] col, input logic [4:0] trow,
                             input logic [31:0] base);
    @(negedge clk);
    flush_start = 1'b1;
    tile_col    = col;
    tile_row    = trow;
    fb_base     = base;
    @(negedge clk);
    flush_start = 1'b0;
    tile_col    = ~col;
    tile_row    = ~trow;
    fb_base     = ~base;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept got=%b exp=1", busy);
    end
  endtask

  // span: cycles from first write cycle to flush_done; -2 if aborted by reset
  task automatic run_flush(input logic [15:0] ref_data [1024],
                           input logic [4:0] col, input logic [4:0] trow,
                           input logic [31:0] base, input int stall_pct,
                           input int abort_at, output int span,
                           output logic [31:0] first_addr);
    int r;
    int w;
    int first;
    bit done;
    r = 0;
    w = 0;
    first = -1;
    done = 1'b0;
    span = -1;
    first_addr = '0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk);
      avm_waitrequest = (stall_pct > 0) &&
                        (int'($urandom_range(99)) < stall_pct);
      if (flush_done) begin
        done = 1'b1;
        span = cyc - first;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_in_last got=%b exp=0", busy);
        end
      end else if (avm_write) begin
        if (first < 0) begin
          first = cyc;
          first_addr = avm_address;
        end
        if (abort_at >= 0 && r * 32 + w == abort_at) begin
          rst = 1'b1;
          #1;
          avm_waitrequest = 1'b0;
          checks++;
          if (avm_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_write got=%b exp=0", avm_write);
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got=%b exp=0", busy);
          end
          span = -2;
          return;
        end
        if (r > 31) begin
          checks++;
          errors++;
          $display("FAIL extra_word got_row=%0d exp_max=31", r);
        end else begin
          checks++;
          if (avm_address !== row_addr(col, trow, r, base)) begin
            errors++;
            $display("FAIL addr row=%0d word=%0d got=%h exp=%h", r, w,
                     avm_address, row_addr(col, trow, r, base));
          end
          checks++;
          if (avm_burstcount !== 6'd32) begin
            errors++;
            $display("FAIL burstcount row=%0d got=%0d exp=32", r,
                     avm_burstcount);
          end
          checks++;
          if (avm_writedata !== ref_data[r*32+w]) begin
            errors++;
            $display("FAIL data row=%0d word=%0d got=%h exp=%h", r, w,
                     avm_writedata, ref_data[r*32+w]);
          end
          if (!avm_waitrequest) begin
            w++;
            if (w == 32) begin
              w = 0;
              r++;
            end
          end
        end
      end
    end
    avm_waitrequest = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL flush_timeout got=no_done exp=flush_done");
    end
    checks++;
    if (r != 32) begin
      errors++;
      $display("FAIL rows_streamed got=%0d exp=32", r);
    end
    @(negedge clk);
    checks++;
    if (flush_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got=%b/%b exp=0/0", flush_done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    checks++;
    if (flush_done !== 1'b0) begin
      errors++; $display("FAIL rst_done got=%b exp=0", flush_done);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL rst_overrun got=%b exp=0", overrun);
    end
    checks++;
    if (avm_write !== 1'b0) begin
      errors++; $display("FAIL rst_write got=%b exp=0", avm_write);
    end
    checks++;
    if (avm_address !== 32'd0) begin
      errors++; $display("FAIL rst_addr got=%h exp=0", avm_address);
    end
    checks++;
    if (avm_writedata !== 16'd0) begin
      errors++; $display("FAIL rst_wdata got=%h exp=0", avm_writedata);
    end
    checks++;
    if (avm_burstcount !== 6'd0) begin
      errors++; $display("FAIL rst_bcount got=%0d exp=0", avm_burstcount);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill_flush();
    int span;
    logic [31:0] fa;
    fill_tile(0);
    tile_done = 1'b1;
    start_flush(5'd2, 5'd1, 32'h0010_0000);
    run_flush(model, 5'd2, 5'd1, 32'h0010_0000, 0, -1, span, fa);
    checks++;
    if (fa !== 32'h0010_A080) begin
      errors++; $display("FAIL first_addr got=%h exp=0010a080", fa);
    end
    checks++;
    if (span != 1055) begin
      errors++; $display("FAIL flush_latency got=%0d exp=1055", span);
    end
  endtask

  task automatic test_stall();
    int span;
    logic [31:0] fa;
    fill_tile(2);
    start_flush(5'd31, 5'd31, 32'hFFFF_F000);
    run_flush(model, 5'd31, 5'd31, 32'hFFFF_F000, 50, -1, span, fa);
    checks++;
    if (fa !== 32'h0013_57C0) begin
      errors++; $display("FAIL wrap_addr got=%h exp=001357c0", fa);
    end
  endtask

  task automatic test_arm_wait();
    int span;
    logic [31:0] fa;
    tile_done = 1'b0;
    start_flush(5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || avm_write !== 1'b0) begin
        errors++;
        $display("FAIL arm_hold cyc=%0d got=%b/%b exp=1/0", i, busy,
                 avm_write);
      end
    end
    tile_done = 1'b1;
    run_flush(model, 5'd0, 5'd0, 32'd0, 0, -1, span, fa);
    checks++;
    if (fa !== 32'd0) begin
      errors++; $display("FAIL arm_first_addr got=%h exp=0", fa);
    end
  endtask

  task automatic test_overrun();
    int span;
    logic [31:0] fa;
    tile_done = 1'b0;
    start_flush(5'd3, 5'd4, 32'h0000_2000);
    @(negedge clk);
    pix_wren = 1'b1; pix_x = 5'd0; pix_y = 5'd0; pix_color = 16'hDEAD;
    @(negedge clk);
    pix_x = 5'd31; pix_y = 5'd31; pix_color = 16'hBEEF;
    @(negedge clk);
    pix_wren = 1'b0;
    flush_start = 1'b1;
    tile_col = 5'd9;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set got=%b exp=1", overrun);
    end
    @(negedge clk);
    flush_start = 1'b0;
    tile_done = 1'b1;
    run_flush(model, 5'd3, 5'd4, 32'h0000_2000, 0, -1, span, fa);
    checks++;
    if (fa !== 32'h0002_A0C0) begin
      errors++; $display("FAIL ovr_first_addr got=%h exp=0002a0c0", fa);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    int span;
    logic [31:0] fa;
    tile_done = 1'b1;
    @(negedge clk);
    flush_start = 1'b1;
    tile_col = 5'd1; tile_row = 5'd0; fb_base = 32'd0;
    pix_wren = 1'b1; pix_x = 5'd9; pix_y = 5'd7; pix_color = 16'h1234;
    model[7*32+9] = 16'h1234;
    @(negedge clk);
    flush_start = 1'b0;
    pix_wren = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_busy got=%b exp=1", busy);
    end
    run_flush(model, 5'd1, 5'd0, 32'd0, 0, -1, span, fa);
    start_flush(5'd4, 5'd2, 32'h4000_0000);
    run_flush(model, 5'd4, 5'd2, 32'h4000_0000, 0, -1, span, fa);
    checks++;
    if (span != 1055) begin
      errors++; $display("FAIL b2b_latency got=%0d exp=1055", span);
    end
  endtask

  task automatic test_reset_mid();
    int span;
    logic [31:0] fa;
    tile_done = 1'b1;
    start_flush(5'd2, 5'd1, 32'h0010_0000);
    run_flush(model, 5'd2, 5'd1, 32'h0010_0000, 0, 5 * 32 + 10, span, fa);
    checks++;
    if (span != -2) begin
      errors++; $display("FAIL abort_reached got=%0d exp=-2", span);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0 || avm_write !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got=%b%b%b exp=000", overrun, busy, avm_write);
    end
    start_flush(5'd2, 5'd1, 32'h0010_0000);
    run_flush(model, 5'd2, 5'd1, 32'h0010_0000, 0, -1, span, fa);
    checks++;
    if (fa !== 32'h0010_A080) begin
      errors++; $display("FAIL restart_addr got=%h exp=0010a080", fa);
    end
  endtask

`ifdef TILE_WB_DOUBLE_BUF_EN
  task automatic test_double_buf();
    int span;
    logic [31:0] fa;
    tile_done = 1'b0;
    fill_tile(0);
    exp_a = model;
    start_flush(5'd2, 5'd1, 32'h0010_0000);
    fork
      fill_tile(1);
      run_flush(exp_a, 5'd2, 5'd1, 32'h0010_0000, 0, -1, span, fa);
    join
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL dbl_overrun got=%b exp=0", overrun);
    end
    checks++;
    if (fa !== 32'h0010_A080) begin
      errors++; $display("FAIL dbl_addr got=%h exp=0010a080", fa);
    end
    exp_a = model;
    start_flush(5'd0, 5'd0, 32'd0);
    run_flush(exp_a, 5'd0, 5'd0, 32'd0, 0, -1, span, fa);
  endtask
`endif

  initial begin
    test_reset();
`ifdef TILE_WB_DOUBLE_BUF_EN
    test_double_buf();
`else
    test_fill_flush();
    test_stall();
    test_arm_wait();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
